// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with a run/target controller.
// Programmable pattern length, overlapping or non-overlapping matches, and a one-cycle match pulse.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               data_valid,
  input  logic               data,
  output logic               result,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [3:0] MAX_L = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [MAX_LEN-1:0] pat_q, hist_q, hist_upd, mask;
  logic [3:0]         len_q, fill_q, fill_upd;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q, cnt_inc;
  logic               acc, match, hit, len_ok;

  // Next history/fill as if the current bit were accepted; match is judged on these.
  assign acc      = (state_q == RUN) && data_valid && !abort;
  assign hist_upd = {hist_q[MAX_LEN-2:0], data};
  assign fill_upd = (fill_q == MAX_L) ? fill_q : fill_q + 4'd1;
  assign mask     = ~({MAX_LEN{1'b1}} << len_q);
  assign match    = acc && (((hist_upd ^ pat_q) & mask) == '0) && (fill_upd >= len_q);
  assign cnt_inc  = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
  assign hit      = (tgt_q != '0) && (cnt_inc == tgt_q);
  assign len_ok   = (cfg_len != 4'd0) && (cfg_len <= MAX_L);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (match && hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      len_q     <= 4'd1;
      ovl_q     <= 1'b1;
      tgt_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_cnt <= '0;
      result    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      result  <= 1'b0;
      cfg_err <= 1'b0;
      if (state_q != RUN && cfg_we) begin
        if (len_ok) begin
          pat_q <= cfg_pattern;
          len_q <= cfg_len;
          ovl_q <= cfg_overlap;
          tgt_q <= cfg_target;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (abort) begin
        match_cnt <= '0;
        hist_q    <= '0;
        fill_q    <= '0;
      end else if (state_q != RUN && start) begin
        match_cnt <= '0;
        hist_q    <= '0;
        fill_q    <= '0;
      end else if (acc) begin
        hist_q <= hist_upd;
        // Non-overlap mode forces the next match to be built from fresh bits.
        fill_q <= (match && !ovl_q) ? 4'd0 : fill_upd;
        if (match) begin
          match_cnt <= cnt_inc;
          result    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: hand-computed pulse positions, counts and state flags.
module tb_seq_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we, cfg_overlap, start, abort, data_valid, data;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               result, busy, done, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .data_valid(data_valid), .data(data),
    .result(result), .match_cnt(match_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("go_busy", 32'(busy), 32'd1);
    chk("go_cnt", 32'(match_cnt), 32'd0);
  endtask

  task automatic kill();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // bits[0] is the first bit sent; exp[i] is the expected result after bit i.
  task automatic run_seq(input logic [15:0] bits, input logic [15:0] exp, input int n,
                         input int gap, input string tag);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1; data = bits[i];
      tick();
      data_valid = 1'b0;
      chk($sformatf("%s_b%0d", tag, i), 32'(result), 32'(exp[i]));
      for (int g = 0; g < gap; g++) begin
        data = ~data;
        tick();
        chk($sformatf("%s_g%0d", tag, i), 32'(result), 32'd0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_target = '0; start = 0; abort = 0; data_valid = 0; data = 0;
    tick(); tick();
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfgerr", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset config is pattern 0, len 1: every accepted 0 matches.
    go();
    run_seq(16'h0002, 16'h0005, 3, 0, "dflt");
    chk("dflt_cnt", 32'(match_cnt), 32'd2);
    kill();

    // Overlap, pattern 1011, stream 1,0,1,1,0,1,1.
    cfg(8'h0B, 4'd4, 1'b1, 8'd0);
    chk("cfg_ok_err", 32'(cfg_err), 32'd0);
    go();
    run_seq(16'h006D, 16'h0048, 7, 0, "ovl");
    chk("ovl_cnt", 32'(match_cnt), 32'd2);
    chk("ovl_busy", 32'(busy), 32'd1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abst_busy", 32'(busy), 32'd0);
    chk("abst_cnt", 32'(match_cnt), 32'd0);

    // Non-overlap.
    cfg(8'h0B, 4'd4, 1'b0, 8'd0);
    go();
    run_seq(16'h006D, 16'h0008, 7, 0, "novl");
    chk("novl_cnt", 32'(match_cnt), 32'd1);
    kill();

    // Target 2: done rises with second pulse, later data ignored.
    cfg(8'h0B, 4'd4, 1'b1, 8'd2);
    go();
    run_seq(16'h006D, 16'h0048, 7, 0, "tgt");
    chk("tgt_done", 32'(done), 32'd1);
    chk("tgt_busy", 32'(busy), 32'd0);
    run_seq(16'h000D, 16'h0000, 4, 0, "tgt_hold");
    chk("tgt_cnt", 32'(match_cnt), 32'd2);
    chk("tgt_done2", 32'(done), 32'd1);
    go();
    kill();

    // Gaps between valid bits.
    cfg(8'h0B, 4'd4, 1'b1, 8'd0);
    go();
    run_seq(16'h006D, 16'h0048, 7, 2, "gap");
    chk("gap_cnt", 32'(match_cnt), 32'd2);
    kill();

    // Rejected lengths keep the 1011 config; writes in RUN are ignored.
    cfg(8'h03, 4'd0, 1'b0, 8'd1);
    chk("len0_err", 32'(cfg_err), 32'd1);
    tick();
    chk("len0_err_clr", 32'(cfg_err), 32'd0);
    cfg(8'h03, 4'd9, 1'b0, 8'd1);
    chk("len9_err", 32'(cfg_err), 32'd1);
    go();
    cfg(8'h02, 4'd2, 1'b1, 8'd0);
    chk("run_cfg_err", 32'(cfg_err), 32'd0);
    run_seq(16'h006D, 16'h0048, 7, 0, "keep");
    chk("keep_cnt", 32'(match_cnt), 32'd2);
    kill();

    // Abort after bit 3, then redetect from cleared history.
    go();
    run_seq(16'h0005, 16'h0000, 3, 0, "pre_ab");
    kill();
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_cnt", 32'(match_cnt), 32'd0);
    chk("ab_result", 32'(result), 32'd0);
    go();
    run_seq(16'h000D, 16'h0008, 4, 0, "post_ab");

    // Asynchronous reset after bit 3.
    kill();
    go();
    run_seq(16'h0005, 16'h0000, 3, 0, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(match_cnt), 32'd0);
    data_valid = 1'b1; data = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("arst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    tick();
    cfg(8'h0B, 4'd4, 1'b1, 8'd0);
    go();
    run_seq(16'h000D, 16'h0008, 4, 0, "post_rst");
    chk("post_rst_cnt", 32'(match_cnt), 32'd1);
    kill();

    // Full-width pattern.
    cfg(8'hA5, 4'd8, 1'b1, 8'd0);
    go();
    run_seq(16'h00A5, 16'h0080, 8, 0, "len8");
    chk("len8_cnt", 32'(match_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of the match counter and target.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port cfg_we, input, 1: configuration write strobe.
REQ-006 Port cfg_pattern, input, MAX_LEN: pattern bits; bit cfg_len-1 is compared against the first-received bit.
REQ-007 Port cfg_len, input, 4: pattern length; legal range 1..MAX_LEN.
REQ-008 Port cfg_overlap, input, 1: 1 = overlapping (cover) detection, 0 = non-overlapping.
REQ-009 Port cfg_target, input, CNT_W: match count that ends a run; 0 = run until abort.
REQ-010 Port start, input, 1: begin a detection run.
REQ-011 Port abort, input, 1: terminate the run and return to IDLE.
REQ-012 Port data_valid, input, 1: data bit is valid this cycle.
REQ-013 Port data, input, 1: serial input bit.
REQ-014 Port result, output, 1: one-cycle match pulse.
REQ-015 Port match_cnt, output, CNT_W: matches counted in the current run.
REQ-016 Port busy, output, 1: high in RUN.
REQ-017 Port done, output, 1: high in DONE.
REQ-018 Port cfg_err, output, 1: one-cycle pulse on a rejected configuration write.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 State transitions SHALL be: IDLE/DONE --start--> RUN; RUN --target reached--> DONE; any state --abort--> IDLE.
REQ-021 If abort and start are asserted in the same cycle, abort SHALL win; start SHALL be ignored while in RUN.
REQ-022 In IDLE or DONE, cfg_we with cfg_len in 1..MAX_LEN SHALL latch pattern, len, overlap and target into internal registers.
REQ-023 In IDLE or DONE, cfg_we with cfg_len equal to 0 or greater than MAX_LEN SHALL leave all configuration registers unchanged and pulse cfg_err in the following cycle.
REQ-024 cfg_we SHALL be ignored in RUN, with no cfg_err pulse.
REQ-025 Entering RUN SHALL clear match_cnt, the history shift register and the fill counter.
REQ-026 In RUN, each data_valid cycle SHALL shift data into the LSB of the history register and increment the fill counter, saturating at MAX_LEN.
REQ-027 A match SHALL occur when the low cfg_len bits of the updated history equal cfg_pattern[cfg_len-1:0] and the updated fill count is at least cfg_len.
REQ-028 Cycles with data_valid low SHALL leave history and fill unchanged and SHALL produce no match.
REQ-029 On a match, result SHALL be high for exactly the one cycle after the edge that accepted the completing bit, i.e. latency is 1 cycle after the accepted bit.
REQ-030 On a match, match_cnt SHALL increment on that same edge, saturating at all-ones.
REQ-031 In overlap mode, a match SHALL NOT alter the fill counter.
REQ-032 In non-overlap mode, a match SHALL zero the fill counter, so the next match needs cfg_len fresh bits.
REQ-033 When cfg_target is nonzero and the incremented match_cnt equals cfg_target, the FSM SHALL enter DONE on the same edge, so done rises together with the final result pulse.
REQ-034 In DONE, data SHALL be ignored and match_cnt SHALL hold its value.
REQ-035 Abort SHALL clear match_cnt and SHALL NOT generate a result pulse.
REQ-036 Data and data_valid SHALL be ignored in IDLE.

Reset
REQ-037 While rst_n is low, the block SHALL be in IDLE with result, match_cnt, busy, done, cfg_err, history and fill all 0.
REQ-038 Reset SHALL load the configuration registers with pattern 0, len 1, overlap 1 and target 0.
REQ-039 Reset asserted mid-RUN SHALL abandon the run immediately, with no result pulse.

Verification
REQ-040 Scenario: pattern 4'b1011, len 4, overlap 1, target 0, start, then valid bits 1,0,1,1,0,1,1 -> result pulses after bits 4 and 7; match_cnt = 2.
REQ-041 Scenario: same stimulus with overlap 0 -> a single result pulse after bit 4; match_cnt = 1.
REQ-042 Scenario: overlap 1, target 2, same stream followed by 1,0,1,1 -> done rises with the second pulse; no further pulses; match_cnt holds 2.
REQ-043 Scenario: data_valid low gaps inserted between the bits of REQ-040 -> pulses occur at the same accepted-bit positions.
REQ-044 Scenario: cfg_we with cfg_len 0 in IDLE -> cfg_err pulses and the previous configuration is retained; cfg_we in RUN -> ignored.
REQ-045 Scenario: abort, and separately rst_n low, after bit 3 of REQ-040 -> IDLE, match_cnt 0, no pulse; a new start redetects from a cleared history.
